// File: rtl/reaction_test_ctrl_pkg.sv
// Shared types and constants for the reaction-time benchmark control path.
package reaction_test_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    GO,
    RESULT,
    EARLY,
    TIMEOUT
  } state_t;

  localparam int unsigned RESULT_W = 14;
  localparam logic [RESULT_W-1:0] BEST_SENTINEL = 14'h3FFF;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting towards the MSB
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/reaction_test_ctrl_ms_tick_gen.sv
// Millisecond prescaler: single-cycle oTick every MS_DIV cycles, restartable via iClear.
module ms_tick_gen #(
  parameter int unsigned MS_DIV = 50000
) (
  input  logic iClock,
  input  logic iResetn,
  input  logic iClear,
  output logic oTick
);

  localparam int unsigned CW = $clog2(MS_DIV);
  localparam logic [CW-1:0] LAST = CW'(MS_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign oTick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (iClear || oTick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reaction_test_ctrl.sv
// Reaction-time trial controller: random wait, GO cue, ms timing of the press,
// session-best tracking and screen-select levels for the display datapath.
module reaction_test_ctrl
  import reaction_test_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 50000000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned DELAY_BITS   = 11,
  parameter int unsigned MAX_RT_MS    = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                iClock,
  input  logic                iResetn,
  input  logic                iEnable,
  input  logic                iStart,
  input  logic                iPress,
  output logic                oWaitScreen,
  output logic                oGoScreen,
  output logic                oTooSoon,
  output logic                oTimeout,
  output logic                oResultValid,
  output logic [RESULT_W-1:0] oResultMs,
  output logic [RESULT_W-1:0] oBestMs,
  output logic                oBestValid
);

  localparam int unsigned MS_DIV = CLK_FREQ_HZ / 1000;
  localparam int unsigned DW     = DELAY_BITS + $clog2(MIN_DELAY_MS + 1) + 1;
  localparam logic [RESULT_W-1:0] MAX_RT = RESULT_W'(MAX_RT_MS);

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [DW-1:0]       delay_q, delay_d;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  logic [RESULT_W-1:0] ms_q, ms_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic [RESULT_W-1:0] best_q, best_d;
  logic                best_valid_q, best_valid_d;
  logic                tick;
  logic                tick_clear;

  ms_tick_gen #(
    .MS_DIV(MS_DIV)
  ) u_ms_tick (
    .iClock (iClock),
    .iResetn(iResetn),
    .iClear (tick_clear),
    .oTick  (tick)
  );

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_next(lfsr_q);
    delay_d      = delay_q;
    dcnt_d       = dcnt_q;
    ms_d         = ms_q;
    result_d     = result_q;
    best_d       = best_q;
    best_valid_d = best_valid_q;
    tick_clear   = 1'b0;

    // Dropping the mode select abandons any trial but keeps published results.
    if (!iEnable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, RESULT, EARLY, TIMEOUT: begin
          if (iStart) begin
            state_d    = ARMED;
            delay_d    = DW'(MIN_DELAY_MS) + DW'(lfsr_q[DELAY_BITS-1:0]);
            dcnt_d     = '0;
            tick_clear = 1'b1;
          end
        end
        ARMED: begin
          if (iPress) begin
            state_d = EARLY;
          end else if (tick) begin
            if (dcnt_q == delay_q - 1'b1) begin
              state_d    = GO;
              ms_d       = '0;
              tick_clear = 1'b1;
            end else begin
              dcnt_d = dcnt_q + 1'b1;
            end
          end
        end
        GO: begin
          // Press wins over the tick that would otherwise expire the window.
          if (iPress) begin
            state_d  = RESULT;
            result_d = ms_q;
            if (!best_valid_q || (ms_q < best_q)) begin
              best_d       = ms_q;
              best_valid_d = 1'b1;
            end
          end else if (tick) begin
            if (ms_q == MAX_RT - 1'b1) begin
              state_d  = TIMEOUT;
              ms_d     = MAX_RT;
              result_d = MAX_RT;
            end else begin
              ms_d = ms_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      delay_q      <= '0;
      dcnt_q       <= '0;
      ms_q         <= '0;
      result_q     <= '0;
      best_q       <= BEST_SENTINEL;
      best_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      delay_q      <= delay_d;
      dcnt_q       <= dcnt_d;
      ms_q         <= ms_d;
      result_q     <= result_d;
      best_q       <= best_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign oWaitScreen  = (state_q == ARMED);
  assign oGoScreen    = (state_q == GO);
  assign oTooSoon     = (state_q == EARLY);
  assign oTimeout     = (state_q == TIMEOUT);
  assign oResultValid = (state_q == RESULT);
  assign oResultMs    = result_q;
  assign oBestMs      = best_q;
  assign oBestValid   = best_valid_q;

endmodule

// File: tb/tb_reaction_test_ctrl.sv
// Scoreboard bench for reaction_test_ctrl: trial-level model predicts each screen
// change (with its latency and published values); a monitor pops and compares.
module tb_reaction_test_ctrl;

  localparam int          MS_DIV  = 4;
  localparam int          MIN_MS  = 2;
  localparam int          MAX_MS  = 50;
  localparam logic [15:0] SEED    = 16'hACE1;

  // screen vector order: {timeout, too_soon, result_valid, go, wait}
  localparam logic [4:0] SCR_NONE    = 5'b00000;
  localparam logic [4:0] SCR_ARMED   = 5'b00001;
  localparam logic [4:0] SCR_GO      = 5'b00010;
  localparam logic [4:0] SCR_RESULT  = 5'b00100;
  localparam logic [4:0] SCR_EARLY   = 5'b01000;
  localparam logic [4:0] SCR_TIMEOUT = 5'b10000;

  localparam int K_NORMAL = 0, K_EARLY = 1, K_TIMEOUT = 2, K_ABORT_ARMED = 3, K_ABORT_GO = 4;

  typedef struct {
    logic [4:0]  scr;
    int          lat;
    logic [13:0] res;
    logic [13:0] best;
    logic        bv;
  } exp_t;

  logic        iClock, iResetn, iEnable, iStart, iPress;
  logic        oWaitScreen, oGoScreen, oTooSoon, oTimeout, oResultValid, oBestValid;
  logic [13:0] oResultMs, oBestMs;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] lfsr_m;
  int          result_m = 0;
  int          best_m   = 'h3FFF;
  bit          bv_m     = 1'b0;

  reaction_test_ctrl #(
    .CLK_FREQ_HZ (MS_DIV * 1000),
    .MIN_DELAY_MS(MIN_MS),
    .DELAY_BITS  (2),
    .MAX_RT_MS   (MAX_MS),
    .LFSR_SEED   (SEED)
  ) dut (
    .iClock      (iClock),
    .iResetn     (iResetn),
    .iEnable     (iEnable),
    .iStart      (iStart),
    .iPress      (iPress),
    .oWaitScreen (oWaitScreen),
    .oGoScreen   (oGoScreen),
    .oTooSoon    (oTooSoon),
    .oTimeout    (oTimeout),
    .oResultValid(oResultValid),
    .oResultMs   (oResultMs),
    .oBestMs     (oBestMs),
    .oBestValid  (oBestValid)
  );

  always #5 iClock = ~iClock;

  // Reference pseudo-random source: x^16+x^14+x^13+x^11, one step per clock.
  always @(posedge iClock or negedge iResetn) begin
    if (!iResetn) lfsr_m <= SEED;
    else          lfsr_m <= (lfsr_m << 1) | 16'(((lfsr_m >> 15) ^ (lfsr_m >> 13) ^ (lfsr_m >> 12) ^ (lfsr_m >> 10)) & 16'd1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input logic [4:0] scr, input int lat);
    exp_t e;
    e.scr  = scr;
    e.lat  = lat;
    e.res  = 14'(result_m);
    e.best = 14'(best_m);
    e.bv   = bv_m;
    q.push_back(e);
  endtask

  // Monitor: every screen change consumes one expected event.
  initial begin
    logic [4:0] prev, scr;
    int         lat_cnt;
    exp_t       e;
    prev    = SCR_NONE;
    lat_cnt = 0;
    forever begin
      @(posedge iClock);
      #1;
      scr = {oTimeout, oTooSoon, oResultValid, oGoScreen, oWaitScreen};
      lat_cnt++;
      chk("onehot_screens", int'($countones(scr) <= 1), 1);
      if (scr != prev) begin
        if (q.size() == 0) begin
          chk("unexpected_change", int'(scr), int'(prev));
        end else begin
          e = q.pop_front();
          chk("screen", int'(scr), int'(e.scr));
          if (e.lat >= 0) chk("latency", lat_cnt, e.lat);
          chk("result_ms", int'(oResultMs), int'(e.res));
          chk("best_ms", int'(oBestMs), int'(e.best));
          chk("best_valid", int'(oBestValid), int'(e.bv));
        end
        prev    = scr;
        lat_cnt = 0;
      end
    end
  end

  // arg: press cycle (normal), press/abort cycle (early/abort); negative = last ARMED cycle.
  task automatic trial(input int kind, input int arg);
    int d, sp, a;
    @(negedge iClock);
    d       = MIN_MS + int'(lfsr_m[1:0]);
    iEnable = 1'b1;
    iStart  = 1'b1;
    iPress  = 1'($urandom_range(0, 1));
    expect_ev(SCR_ARMED, -1);
    @(negedge iClock);
    iStart = 1'b0;
    iPress = 1'b0;
    a = (arg < 0) ? 4 * d - 1 : arg;
    if (kind == K_EARLY || kind == K_ABORT_ARMED) begin
      expect_ev((kind == K_EARLY) ? SCR_EARLY : SCR_NONE, a + 1);
      for (int i = 0; i <= a; i++) begin
        if (kind == K_EARLY) iPress = (i == a);
        else                 iEnable = (i != a);
        @(negedge iClock);
      end
      iPress = 1'b0;
    end else begin
      expect_ev(SCR_GO, 4 * d);
      sp = $urandom_range(0, 4 * d - 1);
      for (int i = 0; i < 4 * d; i++) begin
        iStart = (i == sp);
        @(negedge iClock);
      end
      iStart = 1'b0;
      if (kind == K_NORMAL) begin
        result_m = a / 4;
        if (!bv_m || result_m < best_m) begin
          best_m = result_m;
          bv_m   = 1'b1;
        end
        expect_ev(SCR_RESULT, a + 1);
        for (int i = 0; i <= a; i++) begin
          iPress = (i == a);
          @(negedge iClock);
        end
        iPress = 1'b0;
      end else if (kind == K_TIMEOUT) begin
        result_m = MAX_MS;
        expect_ev(SCR_TIMEOUT, 4 * MAX_MS);
        repeat (4 * MAX_MS) @(negedge iClock);
      end else begin
        expect_ev(SCR_NONE, a + 1);
        for (int i = 0; i <= a; i++) begin
          iEnable = (i != a);
          @(negedge iClock);
        end
      end
    end
    repeat ($urandom_range(1, 3)) @(negedge iClock);
  endtask

  task automatic reset_mid_cycle();
    @(posedge iClock);
    #3;
    result_m = 0;
    best_m   = 'h3FFF;
    bv_m     = 1'b0;
    expect_ev(SCR_NONE, -1);
    iResetn = 1'b0;
    #1;
    chk("async_rst_screens", int'({oTimeout, oTooSoon, oResultValid, oGoScreen, oWaitScreen}), 0);
    chk("async_rst_result", int'(oResultMs), 0);
    chk("async_rst_best", int'(oBestMs), 'h3FFF);
    chk("async_rst_best_valid", int'(oBestValid), 0);
    @(negedge iClock);
    iResetn = 1'b1;
    @(negedge iClock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    iClock  = 1'b0;
    iResetn = 1'b0;
    iEnable = 1'b0;
    iStart  = 1'b0;
    iPress  = 1'b0;
    repeat (3) @(negedge iClock);
    chk("reset_screens", int'({oTimeout, oTooSoon, oResultValid, oGoScreen, oWaitScreen}), 0);
    chk("reset_result", int'(oResultMs), 0);
    chk("reset_best", int'(oBestMs), 'h3FFF);
    chk("reset_best_valid", int'(oBestValid), 0);
    iResetn = 1'b1;
    repeat (2) @(negedge iClock);

    trial(K_NORMAL, 13);
    reset_mid_cycle();
    trial(K_EARLY, 1);
    trial(K_EARLY, -1);
    trial(K_TIMEOUT, 0);
    trial(K_NORMAL, 28);
    trial(K_NORMAL, 16);
    trial(K_NORMAL, 36);
    trial(K_ABORT_GO, 10);
    trial(K_NORMAL, 0);
    trial(K_NORMAL, 199);
    trial(K_ABORT_ARMED, -1);

    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      trial(K_NORMAL, $urandom_range(0, 4 * MAX_MS - 1));
      else if (r <= 6) trial(K_EARLY, -1 - int'($urandom_range(0, 7)) >= -1 ? -1 : $urandom_range(0, 7));
      else if (r == 7) trial(K_ABORT_ARMED, $urandom_range(0, 7));
      else if (r == 8) trial(K_ABORT_GO, $urandom_range(0, 4 * MAX_MS - 1));
      else             trial(K_TIMEOUT, 0);
    end

    repeat (5) @(negedge iClock);
    chk("pending_events", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
